// File: rtl/ro_meas_sequencer.sv
// ro_meas_sequencer
// Command-driven measurement sequencer for the ring-oscillator temperature
// sensor. Each sample clears the edge counter, opens a GATE_CYCLES-long
// oscillator window, waits out the counter synchronizer, and accumulates the
// count. After 2^LOG2_AVG samples the truncated average is published on
// result and sent over the UART as two bytes, low byte first.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   rx_ready     one-cycle pulse, rx_data valid
//   rx_data      command byte: 'M' single burst, 'C' continuous, 'S' stop
//   count        edge counter value, already synchronized to clk
//   tx_busy      UART transmitter busy
//   osc_en       enables ring oscillator and counter
//   cnt_clr      one-cycle synchronous counter clear
//   tx_start     one-cycle UART send request
//   tx_data      byte to send, held until the next tx_start
//   result       latest average
//   result_valid one-cycle pulse when result is updated
//   busy         high whenever the FSM is not IDLE
//   fsm_state    current FSM state encoding, for observation
//
// Handshakes: rx_ready qualifies rx_data for exactly one cycle. tx_start is a
// one-cycle request issued only when tx_busy is low; the transmitter raises
// tx_busy within one cycle of tx_start, so the cycle right after a request
// ignores tx_busy and the byte is considered done once tx_busy falls.
module ro_meas_sequencer #(
  parameter int GATE_CYCLES = 1000,
  parameter int LOG2_AVG    = 3,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  input  logic [CW-1:0] count,
  input  logic          tx_busy,
  output logic          osc_en,
  output logic          cnt_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [CW-1:0] result,
  output logic          result_valid,
  output logic          busy,
  output logic [3:0]    fsm_state
);

  localparam int AW = CW + LOG2_AVG;
  localparam logic [7:0]  LAST_IDX  = 8'((1 << LOG2_AVG) - 1);
  localparam logic [15:0] GATE_LOAD = 16'(GATE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLEAR   = 4'd1,
    S_GATE    = 4'd2,
    S_HOLD    = 4'd3,
    S_SAMPLE  = 4'd4,
    S_DONE    = 4'd5,
    S_TX_LO   = 4'd6,
    S_WAIT_LO = 4'd7,
    S_TX_HI   = 4'd8,
    S_WAIT_HI = 4'd9
  } state_t;

  state_t        state;
  logic          cont;
  logic          first;
  logic [15:0]   timer;
  logic [7:0]    idx;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [15:0]   res_ext;
  logic          cmd_m;
  logic          cmd_c;
  logic          cmd_s;

  assign cmd_m     = rx_ready && (rx_data == 8'h4D);
  assign cmd_c     = rx_ready && (rx_data == 8'h43);
  assign cmd_s     = rx_ready && (rx_data == 8'h53);
  assign sum       = acc + AW'(count);
  assign res_ext   = 16'(result);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cont         <= 1'b0;
      first        <= 1'b0;
      timer        <= '0;
      idx          <= '0;
      acc          <= '0;
      osc_en       <= 1'b0;
      cnt_clr      <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      cnt_clr      <= 1'b0;
      tx_start     <= 1'b0;
      result_valid <= 1'b0;
      if (cmd_s) cont <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_m || cmd_c) begin
            state   <= S_CLEAR;
            cnt_clr <= 1'b1;
            if (cmd_c) cont <= 1'b1;
          end
        end
        S_CLEAR: begin
          osc_en <= 1'b1;
          timer  <= GATE_LOAD;
          state  <= S_GATE;
        end
        S_GATE: begin
          if (timer == 16'd0) begin
            osc_en <= 1'b0;
            timer  <= 16'd1;  // two HOLD cycles
            state  <= S_HOLD;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_HOLD: begin
          if (timer == 16'd0) state <= S_SAMPLE;
          else timer <= timer - 16'd1;
        end
        S_SAMPLE: begin
          // The average is computed here so that result is already updated
          // during the DONE cycle, alongside result_valid.
          if (idx == LAST_IDX) begin
            result       <= CW'(sum >> LOG2_AVG);
            result_valid <= 1'b1;
            acc          <= '0;
            idx          <= '0;
            state        <= S_DONE;
          end else begin
            acc     <= sum;
            idx     <= idx + 8'd1;
            cnt_clr <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_DONE: state <= S_TX_LO;
        S_TX_LO: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= result[7:0];
            first    <= 1'b1;
            state    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (first) first <= 1'b0;
          else if (!tx_busy) state <= S_TX_HI;
        end
        S_TX_HI: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= res_ext[15:8];
            first    <= 1'b1;
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (first) begin
            first <= 1'b0;
          end else if (!tx_busy) begin
            // A stop arriving on this very cycle still wins over cont.
            if (cont && !cmd_s) begin
              cnt_clr <= 1'b1;
              state   <= S_CLEAR;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
module tb_ro_meas_sequencer;

  localparam int G = 10;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] count = 16'h0000;
  logic        tx_busy;
  logic        osc_en, cnt_clr, tx_start, result_valid, busy;
  logic [7:0]  tx_data;
  logic [15:0] result;
  logic [3:0]  fsm_state;

  logic hold_busy = 1'b0;
  logic uart_busy = 1'b0;
  int   uart_cnt = 0;
  assign tx_busy = hold_busy | uart_busy;

  ro_meas_sequencer #(.GATE_CYCLES(G), .LOG2_AVG(L), .CW(16)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .count(count), .tx_busy(tx_busy), .osc_en(osc_en), .cnt_clr(cnt_clr),
    .tx_start(tx_start), .tx_data(tx_data), .result(result),
    .result_valid(result_valid), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // monitor: cycle numbering, event capture, counter and UART models
  int ncyc = 0;
  int base = 0;
  int rel;
  int clr_q[$];
  int osc_cnt, valid_cnt, valid_cyc, txs_cnt, first_tx_cyc, unstable;
  logic [15:0] last_result;
  logic [7:0]  prev_tx_data;
  logic [0:3][15:0] cur_vals;
  int win = 0;

  always @(negedge clk) begin
    ncyc++;
    rel = ncyc - base;
    if (cnt_clr) begin
      clr_q.push_back(rel);
      count = cur_vals[win];
      win = (win + 1) % 4;
    end
    if (osc_en) osc_cnt++;
    if (result_valid) begin
      valid_cnt++;
      valid_cyc = rel;
      last_result = result;
    end
    if (!tx_start && tx_data != prev_tx_data) unstable++;
    prev_tx_data = tx_data;
    if (tx_start) begin
      txs_cnt++;
      if (txs_cnt == 1) first_tx_cyc = rel;
      if (exp_q.size() == 0) chk("tx_unexpected_byte", tx_data, 0);
      else chk("tx_byte", tx_data, exp_q.pop_front());
      uart_busy = 1'b1;
      uart_cnt = 4;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_busy = 1'b0;
    end
  end

  // driver tasks
  task automatic clear_mon(input logic [0:3][15:0] vals);
    clr_q.delete();
    osc_cnt = 0; valid_cnt = 0; valid_cyc = -1; txs_cnt = 0;
    first_tx_cyc = -1; unstable = 0; prev_tx_data = tx_data;
    cur_vals = vals; win = 0;
  endtask

  task automatic send_cmd(input logic [7:0] b, input bit set_base);
    @(negedge clk); #1;
    rx_ready = 1'b1; rx_data = b;
    @(posedge clk);
    if (set_base) base = ncyc;
    #1 rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    if (i == max_cyc) chk(name, 0, 1);
  endtask

  task automatic wait_valid(input int n, input int max_cyc, input string name);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (valid_cnt >= n) break;
    end
    if (i == max_cyc) chk(name, 0, 1);
  endtask

  task automatic push_bytes(input logic [15:0] r);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endtask

  // single 'M' burst with full timing checks
  task automatic run_burst(input logic [0:3][15:0] vals, input logic [15:0] exp_res, input string nm);
    clear_mon(vals);
    push_bytes(exp_res);
    send_cmd(8'h4D, 1'b1);
    wait_idle(1500, {nm, "_timeout"});
    chk({nm, "_clr_count"}, clr_q.size(), 4);
    for (int k = 0; k < 4 && k < clr_q.size(); k++)
      chk({nm, "_clr_cycle"}, clr_q[k], 1 + k * (G + 4));
    chk({nm, "_osc_cycles"}, osc_cnt, 4 * G);
    chk({nm, "_valid_count"}, valid_cnt, 1);
    chk({nm, "_valid_cycle"}, valid_cyc, 4 * (G + 4) + 1);
    chk({nm, "_result"}, last_result, exp_res);
    chk({nm, "_result_held"}, result, exp_res);
    chk({nm, "_tx_count"}, txs_cnt, 2);
    chk({nm, "_bytes_left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    string            name;
    logic [0:3][15:0] vals;
    logic [15:0]      exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{name: "const_1234", vals: {16'h1234, 16'h1234, 16'h1234, 16'h1234}, exp_res: 16'h1234};
    vecs[1] = '{name: "avg_407",    vals: {16'd100, 16'd101, 16'd102, 16'd104},      exp_res: 16'd101};
    vecs[2] = '{name: "max_ffff",   vals: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_res: 16'hFFFF};
    vecs[3] = '{name: "trunc_zero", vals: {16'd0, 16'd0, 16'd0, 16'd3},             exp_res: 16'd0};
    vecs[4] = '{name: "trunc_11",   vals: {16'd1, 16'd2, 16'd3, 16'd5},             exp_res: 16'd2};
    vecs[5] = '{name: "carry_402",  vals: {16'h00FF, 16'h0100, 16'h0101, 16'h0102}, exp_res: 16'h0100};

    // reset state
    cur_vals = {16'h0, 16'h0, 16'h0, 16'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_osc_en", osc_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single bursts
    foreach (vecs[i]) run_burst(vecs[i].vals, vecs[i].exp_res, vecs[i].name);

    // continuous mode, stop during third GATE
    clear_mon({16'h1234, 16'h1234, 16'h1234, 16'h1234});
    for (int k = 0; k < 3; k++) push_bytes(16'h1234);
    send_cmd(8'h43, 1'b1);
    wait_valid(2, 1500, "cont_two_results_timeout");
    begin
      int i;
      for (i = 0; i < 500; i++) begin
        @(negedge clk); #1;
        if (clr_q.size() >= 9 && osc_en) break;
      end
      if (i == 500) chk("cont_third_gate_timeout", 0, 1);
    end
    send_cmd(8'h53, 1'b0);
    wait_idle(1500, "cont_stop_timeout");
    repeat (20) @(negedge clk);
    #1;
    chk("cont_valid_count", valid_cnt, 3);
    chk("cont_tx_count", txs_cnt, 6);
    chk("cont_clr_count", clr_q.size(), 12);
    chk("cont_idle", busy, 0);
    chk("cont_bytes_left", exp_q.size(), 0);

    // transmitter held busy for 50 cycles after DONE
    clear_mon({16'h1234, 16'h1234, 16'h1234, 16'h1234});
    push_bytes(16'h1234);
    send_cmd(8'h4D, 1'b1);
    wait_valid(1, 1500, "hold_valid_timeout");
    hold_busy = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("hold_no_tx_yet", txs_cnt, 0);
    chk("hold_state_tx_lo", fsm_state, 6);
    hold_busy = 1'b0;
    begin
      int r;
      r = ncyc - base;
      wait_idle(500, "hold_timeout");
      chk("hold_first_tx_cycle", first_tx_cyc, r + 1);
    end
    chk("hold_tx_data_stable", unstable, 0);
    chk("hold_tx_count", txs_cnt, 2);

    // 'S' on the same cycle WAIT_HI sees tx_busy low
    clear_mon({16'h0055, 16'h0055, 16'h0055, 16'h0055});
    push_bytes(16'h0055);
    send_cmd(8'h43, 1'b1);
    begin
      int i;
      for (i = 0; i < 1500; i++) begin
        @(negedge clk); #1;
        if (txs_cnt >= 2) break;
      end
      if (i == 1500) chk("stop_exit_timeout", 0, 1);
    end
    hold_busy = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("stop_exit_in_wait_hi", fsm_state, 9);
    @(negedge clk); #1;
    hold_busy = 1'b0; rx_ready = 1'b1; rx_data = 8'h53;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("stop_exit_idle", busy, 0);
    chk("stop_exit_no_clear", clr_q.size(), 4);
    chk("stop_exit_valid_count", valid_cnt, 1);

    // asynchronous reset in the middle of GATE
    clear_mon({16'h1234, 16'h1234, 16'h1234, 16'h1234});
    send_cmd(8'h4D, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("arst_in_gate", osc_en, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_osc_en", osc_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_tx_data", tx_data, 0);
    @(negedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    // a stale accumulator or sample index would corrupt this result
    run_burst(vecs[1].vals, vecs[1].exp_res, "after_reset");

    // unknown byte, then commands while busy are ignored
    clear_mon({16'h0200, 16'h0200, 16'h0200, 16'h0200});
    send_cmd(8'h41, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("unknown_cmd_busy", busy, 0);
    chk("unknown_cmd_clr", clr_q.size(), 0);
    push_bytes(16'h0200);
    send_cmd(8'h4D, 1'b1);
    repeat (20) @(negedge clk);
    send_cmd(8'h4D, 1'b0);
    repeat (10) @(negedge clk);
    send_cmd(8'h43, 1'b0);
    wait_idle(1500, "ignore_timeout");
    repeat (30) @(negedge clk);
    #1;
    chk("ignore_valid_count", valid_cnt, 1);
    chk("ignore_clr_count", clr_q.size(), 4);
    chk("ignore_tx_count", txs_cnt, 2);
    chk("ignore_result", last_result, 16'h0200);
    chk("ignore_stays_idle", busy, 0);
    chk("ignore_bytes_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
